// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - calculator keypad debouncer, key decoder and ALU sequencer
//
// Debounces a 4x5 active-low switch matrix. Decodes one key event at a time and
// builds operands A/B by decimal entry. Launches the arithmetic unit with a
// start/done handshake and latches its result into regA.
//
// Ports:
//   sys_clk, rst_n            clock (rising edge), asynchronous active-low reset
//   input_row1..input_row4    switch rows, 0 = pressed
//   alu_start                 one-cycle launch pulse (EXEC state)
//   alu_op, alu_a, alu_b      operation and operands, held from start to done
//   alu_done                  one-cycle completion pulse
//   alu_result, alu_sign, alu_err  completion data, valid with alu_done
//   regA, regB, sign          display registers (A entry/result, B entry, sign of regA)
//   err                       error indicator
//   busy                      high while an operation is in flight (EXEC/WAIT/FLUSH)
//   beep                      key-accept tone, BEEP_CYCLES long
module calc_key_sequencer #(
    parameter int W           = 32,
    parameter int MAX_DIGITS  = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int BEEP_CYCLES = 1000
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic [4:0]   input_row1,
    input  logic [4:0]   input_row2,
    input  logic [4:0]   input_row3,
    input  logic [4:0]   input_row4,
    output logic         alu_start,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_sign,
    input  logic         alu_err,
    output logic [W-1:0] regA,
    output logic [W-1:0] regB,
    output logic         sign,
    output logic         err,
    output logic         busy,
    output logic         beep
);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int BW  = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_WAIT, S_RES, S_ERR, S_FLUSH} state_t;
    typedef enum logic [2:0] {K_NONE, K_DIG, K_OP, K_SQ, K_EQ, K_CE, K_AC} key_t;

    // Key index = (row-1)*5 + column, row1 in bits 4:0 ... row4 in bits 19:15.
    function automatic int dig_pos(input int d);
        case (d)
            0:       return 15;
            1:       return 10;
            2:       return 11;
            3:       return 12;
            4:       return 5;
            5:       return 6;
            6:       return 7;
            7:       return 0;
            8:       return 1;
            default: return 2;
        endcase
    endfunction

    // ---------------- synchronizer and debounce ----------------
    logic [19:0]    sync1, sync2;
    logic [19:0]    pressed, pressed_evt;
    logic [DCW-1:0] deb_cnt [20];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {input_row4, input_row3, input_row2, input_row1};
            sync2 <= sync1;
        end
    end

    // The counter runs only while the sample disagrees with the debounced
    // state, so one agreeing sample restarts the qualification window.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed     <= '0;
            pressed_evt <= '0;
            for (int i = 0; i < 20; i++) deb_cnt[i] <= '0;
        end else begin
            pressed_evt <= '0;
            for (int i = 0; i < 20; i++) begin
                if (sync2[i] == ~pressed[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb_cnt[i]     <= '0;
                    pressed[i]     <= ~pressed[i];
                    pressed_evt[i] <= ~pressed[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    // Positions 16 and 18 are debounced but carry no function.
    logic unused_keys;
    assign unused_keys = pressed_evt[16] ^ pressed_evt[18];

    // ---------------- priority key decode ----------------
    key_t       key;
    logic [3:0] key_dig;
    logic [2:0] key_op;

    always_comb begin
        key     = K_NONE;
        key_dig = '0;
        key_op  = '0;
        if (pressed_evt[3])       key = K_AC;
        else if (pressed_evt[4])  key = K_CE;
        else if (pressed_evt[19]) key = K_EQ;
        else if (pressed_evt[17]) key = K_SQ;
        else if (pressed_evt[9])  begin key = K_OP; key_op = 3'b011; end
        else if (pressed_evt[14]) begin key = K_OP; key_op = 3'b010; end
        else if (pressed_evt[8])  begin key = K_OP; key_op = 3'b001; end
        else if (pressed_evt[13]) begin key = K_OP; key_op = 3'b000; end
        else begin
            // Descending scan so the lowest simultaneous digit is the one kept.
            for (int d = 9; d >= 0; d--) begin
                if (pressed_evt[dig_pos(d)]) begin
                    key     = K_DIG;
                    key_dig = 4'(d);
                end
            end
        end
    end

    // ---------------- sequencer ----------------
    state_t         state, state_n;
    logic [W-1:0]   regA_n, regB_n, alu_a_n, alu_b_n;
    logic           sign_n, err_n;
    logic [2:0]     op, op_n, pend_op, pend_op_n, alu_op_n;
    logic           pend_v, pend_v_n, b_ent, b_ent_n;
    logic [CW-1:0]  dig_cnt, dig_cnt_n;
    logic [BW-1:0]  beep_cnt;
    logic           accept, do_clear, do_launch;
    logic [2:0]     launch_op;
    logic [W-1:0]   launch_b, cur_entry, next_entry;
    logic           dig_room, lead_zero;

    assign cur_entry  = (state == S_B) ? regB : regA;
    assign next_entry = cur_entry * W'(10) + W'(key_dig);
    assign dig_room   = dig_cnt < CW'(MAX_DIGITS);
    assign lead_zero  = (dig_cnt == '0) && (key_dig == 4'd0);

    always_comb begin
        state_n   = state;
        regA_n    = regA;
        regB_n    = regB;
        sign_n    = sign;
        err_n     = err;
        op_n      = op;
        pend_op_n = pend_op;
        pend_v_n  = pend_v;
        b_ent_n   = b_ent;
        dig_cnt_n = dig_cnt;
        alu_op_n  = alu_op;
        alu_a_n   = alu_a;
        alu_b_n   = alu_b;
        accept    = 1'b0;
        do_clear  = 1'b0;
        do_launch = 1'b0;
        launch_op = op;
        launch_b  = regB;

        case (state)
            S_A, S_B: begin
                case (key)
                    K_AC: begin do_clear = 1'b1; accept = 1'b1; end
                    K_CE: begin
                        accept    = 1'b1;
                        dig_cnt_n = '0;
                        if (state == S_A) regA_n = '0;
                        else begin regB_n = '0; b_ent_n = 1'b0; end
                    end
                    K_DIG: begin
                        if (dig_room) begin
                            accept = 1'b1;
                            if (state == S_B) b_ent_n = 1'b1;
                            if (!lead_zero) begin
                                dig_cnt_n = dig_cnt + CW'(1);
                                if (state == S_A) regA_n = next_entry;
                                else              regB_n = next_entry;
                            end
                        end
                    end
                    K_OP: begin
                        accept = 1'b1;
                        if (state == S_B && b_ent) begin
                            do_launch = 1'b1;
                            pend_op_n = key_op;
                            pend_v_n  = 1'b1;
                        end else begin
                            op_n      = key_op;
                            regB_n    = '0;
                            dig_cnt_n = '0;
                            b_ent_n   = 1'b0;
                            pend_v_n  = 1'b0;
                            state_n   = S_B;
                        end
                    end
                    K_SQ: begin
                        if (state == S_A) begin
                            accept    = 1'b1;
                            do_launch = 1'b1;
                            launch_op = 3'b100;
                            launch_b  = '0;
                            regB_n    = '0;
                        end
                    end
                    K_EQ: begin
                        if (state == S_A) begin
                            accept = 1'b1;
                        end else if (b_ent) begin
                            accept    = 1'b1;
                            do_launch = 1'b1;
                            pend_v_n  = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                state_n = S_WAIT;
                if (key == K_AC) begin accept = 1'b1; state_n = S_FLUSH; end
            end
            S_WAIT: begin
                if (key == K_AC) begin
                    accept = 1'b1;
                    // A done arriving with the AC is already the one to discard.
                    if (alu_done) do_clear = 1'b1;
                    else          state_n  = S_FLUSH;
                end else if (alu_done) begin
                    if (alu_err) begin
                        err_n   = 1'b1;
                        state_n = S_ERR;
                    end else begin
                        regA_n    = alu_result;
                        sign_n    = alu_sign;
                        regB_n    = '0;
                        dig_cnt_n = '0;
                        b_ent_n   = 1'b0;
                        if (pend_v) begin
                            op_n     = pend_op;
                            pend_v_n = 1'b0;
                            state_n  = S_B;
                        end else begin
                            state_n  = S_RES;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (alu_done) do_clear = 1'b1;
            end
            S_RES: begin
                case (key)
                    K_AC: begin do_clear = 1'b1; accept = 1'b1; end
                    K_DIG: begin
                        accept    = 1'b1;
                        regA_n    = W'(key_dig);
                        sign_n    = 1'b0;
                        dig_cnt_n = (key_dig == 4'd0) ? CW'(0) : CW'(1);
                        state_n   = S_A;
                    end
                    K_OP: begin
                        accept    = 1'b1;
                        op_n      = key_op;
                        regB_n    = '0;
                        dig_cnt_n = '0;
                        b_ent_n   = 1'b0;
                        pend_v_n  = 1'b0;
                        state_n   = S_B;
                    end
                    K_SQ: begin
                        accept    = 1'b1;
                        do_launch = 1'b1;
                        launch_op = 3'b100;
                        launch_b  = '0;
                        regB_n    = '0;
                    end
                    default: ;
                endcase
            end
            S_ERR: begin
                if (key == K_AC) begin do_clear = 1'b1; accept = 1'b1; end
            end
            default: state_n = S_A;
        endcase

        // regA is used as a magnitude; its sign stays in `sign` across a chain.
        if (do_launch) begin
            alu_op_n  = launch_op;
            alu_a_n   = regA;
            alu_b_n   = launch_b;
            dig_cnt_n = '0;
            state_n   = S_EXEC;
        end

        if (do_clear) begin
            state_n   = S_A;
            regA_n    = '0;
            regB_n    = '0;
            sign_n    = 1'b0;
            err_n     = 1'b0;
            op_n      = '0;
            pend_op_n = '0;
            pend_v_n  = 1'b0;
            b_ent_n   = 1'b0;
            dig_cnt_n = '0;
            alu_op_n  = '0;
            alu_a_n   = '0;
            alu_b_n   = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            regA     <= '0;
            regB     <= '0;
            sign     <= 1'b0;
            err      <= 1'b0;
            op       <= '0;
            pend_op  <= '0;
            pend_v   <= 1'b0;
            b_ent    <= 1'b0;
            dig_cnt  <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            beep_cnt <= '0;
        end else begin
            state    <= state_n;
            regA     <= regA_n;
            regB     <= regB_n;
            sign     <= sign_n;
            err      <= err_n;
            op       <= op_n;
            pend_op  <= pend_op_n;
            pend_v   <= pend_v_n;
            b_ent    <= b_ent_n;
            dig_cnt  <= dig_cnt_n;
            alu_op   <= alu_op_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            if (accept)                beep_cnt <= BW'(BEEP_CYCLES);
            else if (beep_cnt != '0)   beep_cnt <= beep_cnt - BW'(1);
        end
    end

    assign alu_start = (state == S_EXEC);
    assign busy      = (state == S_EXEC) || (state == S_WAIT) || (state == S_FLUSH);
    assign beep      = (beep_cnt != '0);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed bench for calc_key_sequencer with an ALU stub
module tb_calc_key_sequencer;
    localparam int DEB  = 16;
    localparam int BEEP = 60;
    localparam int HOLD = DEB + 8;

    localparam int K_PLUS = 13, K_MINUS = 8, K_MUL = 14, K_DIV = 9;
    localparam int K_SQ = 17, K_AC = 3, K_CE = 4, K_EQ = 19;
    int dig_key [10] = '{15, 10, 11, 12, 5, 6, 7, 0, 1, 2};

    logic        sys_clk, rst_n;
    logic [19:0] sw_n;
    logic        alu_start, alu_done, alu_sign, alu_err;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result, regA, regB;
    logic        sign, err, busy, beep;

    int vectors = 0;
    int miscompares = 0;

    calc_key_sequencer #(.W(32), .MAX_DIGITS(8), .DEB_CYCLES(DEB), .BEEP_CYCLES(BEEP)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .input_row1(sw_n[4:0]), .input_row2(sw_n[9:5]),
        .input_row3(sw_n[14:10]), .input_row4(sw_n[19:15]),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_sign(alu_sign), .alu_err(alu_err),
        .regA(regA), .regB(regB), .sign(sign), .err(err), .busy(busy), .beep(beep)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ALU stub: answers `lat` negedges after seeing alu_start.
    int          lat = 3;
    int          cnt = 0;
    int          start_cnt = 0;
    int          busy_cnt = 0;
    bit          pending = 0;
    bit          stray = 0;
    logic [2:0]  cap_op;
    logic [31:0] cap_a, cap_b;

    initial begin
        alu_done = 1'b0; alu_err = 1'b0; alu_sign = 1'b0; alu_result = '0;
    end

    always @(negedge sys_clk) begin
        if (alu_start === 1'b1) busy_cnt = 0;
        if (busy === 1'b1) busy_cnt++;
        alu_done = 1'b0;
        alu_err  = 1'b0;
        if (stray) begin
            alu_done = 1'b1; alu_result = 32'd99; alu_sign = 1'b0; stray = 0;
        end else if (pending) begin
            if (cnt <= 1) begin
                alu_done = 1'b1; alu_sign = 1'b0; alu_result = '0; pending = 0;
                case (cap_op)
                    3'd0: alu_result = cap_a + cap_b;
                    3'd1: if (cap_a >= cap_b) alu_result = cap_a - cap_b;
                          else begin alu_result = cap_b - cap_a; alu_sign = 1'b1; end
                    3'd2: alu_result = cap_a * cap_b;
                    3'd3: if (cap_b == 0) alu_err = 1'b1; else alu_result = cap_a / cap_b;
                    default: alu_result = cap_a * cap_a;
                endcase
            end else begin
                cnt--;
            end
        end
        if (alu_start === 1'b1) begin
            pending = 1; cnt = lat; cap_op = alu_op; cap_a = alu_a; cap_b = alu_b; start_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int k);
        @(negedge sys_clk);
        sw_n[k] = 1'b0;
        repeat (HOLD) @(negedge sys_clk);
        sw_n[k] = 1'b1;
        repeat (HOLD) @(negedge sys_clk);
    endtask

    task automatic type_num(input int v);
        int digs[$];
        if (v == 0) digs.push_front(0);
        while (v > 0) begin
            digs.push_front(v % 10);
            v = v / 10;
        end
        foreach (digs[i]) press(dig_key[digs[i]]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit timed_out;
        rst_n = 1'b0;
        sw_n  = '1;
        repeat (3) @(negedge sys_clk);
        check("rst_regA", regA, 0);
        check("rst_regB", regB, 0);
        check("rst_sign", sign, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_beep", beep, 0);
        check("rst_start", alu_start, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // 7 / 3 =
        press(dig_key[7]);
        check("digit7_regA", regA, 7);
        check("digit7_beep", beep, 1);
        press(K_DIV);
        press(dig_key[3]);
        check("b3_regB", regB, 3);
        start_cnt = 0;
        press(K_EQ);
        check("div_starts", start_cnt, 1);
        check("div_op", cap_op, 3);
        check("div_a", cap_a, 7);
        check("div_b", cap_b, 3);
        check("div_regA", regA, 2);
        check("div_regB", regB, 0);
        check("div_busy_len", busy_cnt, lat + 1);
        check("div_busy_after", busy, 0);
        press(dig_key[5]);
        check("res_digit_restart", regA, 5);

        // 2345 * 5678 =
        press(K_AC);
        type_num(2345);
        press(K_MUL);
        type_num(5678);
        press(K_EQ);
        check("mul_regA", regA, 13314910);
        check("mul_sign", sign, 0);
        check("mul_op", cap_op, 2);
        check("mul_busy_len", busy_cnt, lat + 1);

        // 31 - 50 = then + 4 =
        press(K_AC);
        type_num(31);
        press(K_MINUS);
        type_num(50);
        press(K_EQ);
        check("sub_regA", regA, 19);
        check("sub_sign", sign, 1);
        press(K_PLUS);
        press(dig_key[4]);
        press(K_EQ);
        check("chain_a", cap_a, 19);
        check("chain_op", cap_op, 0);
        check("chain_regA", regA, 23);

        // CE in A entry
        press(K_AC);
        type_num(12);
        press(K_CE);
        press(dig_key[3]);
        check("ce_regA", regA, 3);

        // Bounce shorter than the debounce window
        press(K_AC);
        press(dig_key[6]);
        repeat (BEEP) @(negedge sys_clk);
        for (int r = 0; r < 5; r++) begin
            sw_n[11] = 1'b0;
            repeat (DEB - 1) @(negedge sys_clk);
            sw_n[11] = 1'b1;
            repeat (5) @(negedge sys_clk);
        end
        repeat (DEB + 4) @(negedge sys_clk);
        check("bounce_regA", regA, 6);
        check("bounce_beep", beep, 0);

        // Nine digits: only eight kept, ninth not beeped
        press(K_AC);
        type_num(12345678);
        check("digit8_beep", beep, 1);
        press(dig_key[9]);
        check("max_digits_regA", regA, 12345678);
        check("digit9_nobeep", beep, 0);

        // AC and digit 0 on the same cycle
        press(K_AC);
        press(dig_key[5]);
        @(negedge sys_clk);
        sw_n[K_AC] = 1'b0;
        sw_n[dig_key[0]] = 1'b0;
        repeat (HOLD) @(negedge sys_clk);
        sw_n[K_AC] = 1'b1;
        sw_n[dig_key[0]] = 1'b1;
        repeat (HOLD) @(negedge sys_clk);
        check("simul_ac_regA", regA, 0);

        // 5 / 0 = -> error
        press(dig_key[5]);
        press(K_DIV);
        press(dig_key[0]);
        press(K_EQ);
        check("div0_err", err, 1);
        press(dig_key[3]);
        check("err_digit_ignored", regA, 5);
        press(K_AC);
        check("err_ac_clear", err, 0);
        check("err_ac_regA", regA, 0);
        press(dig_key[4]);
        check("after_err_entry", regA, 4);

        // AC while waiting for the ALU
        press(K_AC);
        lat = 200;
        press(dig_key[6]);
        press(K_PLUS);
        press(dig_key[1]);
        press(K_EQ);
        check("wait_busy", busy, 1);
        press(K_AC);
        check("flush_busy", busy, 1);
        timed_out = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (busy === 1'b0) begin timed_out = 0; break; end
        end
        check("flush_timeout", timed_out, 0);
        check("flush_regA", regA, 0);
        check("flush_sign", sign, 0);
        stray = 1;
        repeat (4) @(negedge sys_clk);
        check("stray_done_regA", regA, 0);
        press(dig_key[8]);
        check("after_flush_entry", regA, 8);

        // Reset in the middle of an operation
        press(K_AC);
        press(dig_key[2]);
        press(K_PLUS);
        press(dig_key[3]);
        press(K_EQ);
        check("midop_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", busy, 0);
        check("midop_rst_regA", regA, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (250) @(negedge sys_clk);
        check("late_done_regA", regA, 0);
        check("late_done_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
